nanov_word_serialiser: RTL
==========================

// Module: nanoV_word_serialiser
// PURPOSE
//   Parallel<->bit-serial bridge for the nanoV bit-serial register file.
//   Accepts one parallel word per transaction (valid/ready) and drives it LSB-first onto the
//   register file's serial write bit. Over the same WIDTH bit-cycles it captures the two
//   serial read streams (rs1, rs2) and presents them as parallel words (valid/ready).
//   Sits between parallel test/debug logic or a parallel load path and nanoV_registers.
// PARAMETERS
//   WIDTH     32               bits per word, i.e. serial beats per transaction
//   CNT_BITS  $clog2(WIDTH)    width of the bit counter (5 for WIDTH=32)
// PORTS
//   clk       in   1          clock; all state changes on posedge
//   rstn      in   1          synchronous active-low reset
//   pause     in   1          1 = stall serial stream this cycle (counter and shifts hold)
//   in_valid  in   1          parallel word offered
//   in_ready  out  1          bridge can accept a word (high only in IDLE)
//   in_data   in   WIDTH      word to serialise onto wr_bit
//   in_wr     in   1          1 = assert wr_en during the run; 0 = read-only run
//   wr_en     out  1          serial write enable to register file
//   wr_bit    out  1          serial write data, LSB first
//   bit_cnt   out  CNT_BITS   index of the bit currently on the serial interface
//   data_rs1  in   1          serial read bit from register file, rs1 port
//   data_rs2  in   1          serial read bit from register file, rs2 port
//   out_valid out  1          captured words available
//   out_ready in   1          consumer accepts captured words
//   rs1_word  out  WIDTH      captured rs1 word
//   rs2_word  out  WIDTH      captured rs2 word
// BEHAVIOUR
//   States: IDLE -> RUN -> DONE -> IDLE.
//   Reset (rstn=0 at posedge): state=IDLE, bit_cnt=0, shift/rs1_word/rs2_word=0,
//     wr_mode=0; outputs: in_ready=1, wr_en=0, wr_bit=0, out_valid=0.
//   Reset wins over every other event, including mid-RUN and in DONE: no partial word is kept.
//   IDLE: in_ready=1. On in_valid: latch in_data into shift, in_wr into wr_mode,
//     bit_cnt<=0, clear rs1_word/rs2_word, go to RUN next cycle. pause is ignored in IDLE.
//   RUN: in_ready=0.
//     Beat cycle = (state==RUN && !pause).
//     wr_en = beat && wr_mode (combinational).
//     wr_bit = shift[0] (combinational from the register; 0 outside RUN).
//     On each beat:
//       - shift >>= 1
//       - rs1_word <= {data_rs1, rs1_word[WIDTH-1:1]}
//       - rs2_word <= {data_rs2, rs2_word[WIDTH-1:1]}
//       - bit_cnt <= bit_cnt+1, wrapping to 0 after WIDTH-1
//     pause=1: bit_cnt, shift and capture registers all hold; wr_en=0.
//     Beat with bit_cnt==WIDTH-1: bit_cnt wraps to 0 and state goes to DONE.
//   Latency: unpaused run is WIDTH cycles after acceptance. out_valid rises on the
//     (WIDTH+1)th cycle after the in_valid/in_ready handshake; each paused cycle adds 1.
//   DONE: out_valid=1 and rs1_word/rs2_word held stable until out_ready.
//     On out_ready: state=IDLE, out_valid=0 next cycle. in_ready stays 0 throughout DONE,
//     so there is no overlap and a new word cannot be accepted in the same cycle.
//   A pause arriving on the final beat delays completion; no bit is lost or duplicated.
//   bit_cnt equals the index of the bit on wr_bit and the index being captured this beat.
// TESTING
//   1. Reset, in_data=32'hA5A5_0F0F, in_wr=1, data_rs1 driven from 32'h1234_5678 per bit_cnt,
//      no pause -> wr_bit sequence equals in_data LSB-first; wr_en high for exactly 32 cycles;
//      rs1_word=32'h1234_5678; out_valid rises 33 cycles after the handshake.
//   2. Same as 1 with pause high on bit_cnt=0, 7 (3 cycles) and 31 -> identical words,
//      out_valid delayed by exactly 5 cycles, wr_en=0 during every pause cycle.
//   3. in_wr=0, data_rs2 stream 32'hFFFF_0000 -> wr_en never asserts; rs2_word=32'hFFFF_0000.
//   4. Hold out_ready=0 for 10 cycles in DONE while in_valid=1 -> in_ready=0, words stable;
//      on out_ready=1, return to IDLE and accept the next word one cycle later.
//   5. rstn=0 at bit_cnt=17 -> next cycle IDLE, bit_cnt=0, wr_en=0, out_valid=0,
//      rs1_word/rs2_word=0.
//   6. Back-to-back transactions 32'h0000_0001 then 32'h8000_0000, data_rs1 tied 1 ->
//      both rs1_word=32'hFFFF_FFFF; wr_bit high only at bit 0, then only at bit 31.

Source files
------------

// File: rtl/nanov_word_serialiser_if.sv
// Bus bundle between parallel logic and the bit-serial register-file bridge.
// The master is the parallel-side client; the slave is the serialiser itself.
interface nanov_word_serialiser_if #(
  parameter int WIDTH = 32
);
  localparam int CNT_BITS = $clog2(WIDTH);

  logic                pause;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                in_wr;
  logic                wr_en;
  logic                wr_bit;
  logic [CNT_BITS-1:0] bit_cnt;
  logic                data_rs1;
  logic                data_rs2;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    rs1_word;
  logic [WIDTH-1:0]    rs2_word;

  modport master (
    output pause, in_valid, in_data, in_wr, data_rs1, data_rs2, out_ready,
    input  in_ready, wr_en, wr_bit, bit_cnt, out_valid, rs1_word, rs2_word
  );

  modport slave (
    input  pause, in_valid, in_data, in_wr, data_rs1, data_rs2, out_ready,
    output in_ready, wr_en, wr_bit, bit_cnt, out_valid, rs1_word, rs2_word
  );
endinterface

// File: rtl/nanov_word_serialiser.sv
// Parallel <-> bit-serial bridge for the nanoV register file.
// One word is shifted out LSB-first on wr_bit while the rs1/rs2 serial read
// streams are captured into parallel words over the same WIDTH beats.
//
// state | meaning
// IDLE  | waiting for a parallel word, in_ready high
// RUN   | streaming one bit per unpaused cycle, bit_cnt = current bit index
// DONE  | captured words presented on out_valid until out_ready
module nanov_word_serialiser #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  nanov_word_serialiser_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIDTH - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  state_e              state_q;
  logic [CNT_BITS-1:0] bit_cnt_q;
  logic [WIDTH-1:0]    shift_q;
  logic [WIDTH-1:0]    rs1_q;
  logic [WIDTH-1:0]    rs2_q;
  logic                wr_mode_q;
  logic                beat;

  // A beat is a RUN cycle that is not stalled; everything serial advances on it.
  assign beat = (state_q == RUN) && !bus.pause;

  // Sequencer, counter, write shifter and read capture in one register block.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      wr_mode_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            shift_q   <= bus.in_data;
            wr_mode_q <= bus.in_wr;
            bit_cnt_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (!bus.pause) begin
            shift_q <= shift_q >> 1;
            rs1_q   <= {bus.data_rs1, rs1_q[WIDTH-1:1]};
            rs2_q   <= {bus.data_rs2, rs2_q[WIDTH-1:1]};
            if (bit_cnt_q == CNT_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_ONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register; the serial
  // write pins are gated so nothing toggles outside RUN.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.wr_en     = beat && wr_mode_q;
    bus.wr_bit    = (state_q == RUN) && shift_q[0];
    bus.bit_cnt   = bit_cnt_q;
    bus.rs1_word  = rs1_q;
    bus.rs2_word  = rs2_q;
  end

endmodule
